// File: rtl/ew_sim_pkg.sv
// Shared types for the EW threat controller: FSM state codes, threat codes and log record header.
// Build option EW_TIMESTAMP_EN adds a 16-bit cycle stamp to each log record header.
package ew_sim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_JAMMED         = 3'd1,
        ST_SPOOF_DETECTED = 3'd2,
        ST_AUTHENTICATING = 3'd3,
        ST_RECOVERY       = 3'd4,
        ST_LOGGING        = 3'd5,
        ST_THREAT_KNOWN   = 3'd6,
        ST_FAULT          = 3'd7
    } ew_state_e;

    typedef enum logic [2:0] {
        THR_NONE       = 3'd0,
        THR_JAM        = 3'd1,
        THR_SPOOF_CLR  = 3'd2,
        THR_SPOOF_CONF = 3'd3
    } ew_threat_e;

    localparam int TS_W = 16;

`ifdef EW_TIMESTAMP_EN
    localparam int META_W = TS_W + 3;
    typedef struct packed {
        logic [TS_W-1:0] stamp;
        ew_threat_e      threat;
    } ew_log_meta_t;
`else
    localparam int META_W = 3;
    typedef struct packed {
        ew_threat_e threat;
    } ew_log_meta_t;
`endif

    // Record layout is {meta, channel, signal}; the meta part is the struct above.
    function automatic int ew_log_width(input int dw, input int n_ch);
        return META_W + $clog2(n_ch) + dw;
    endfunction

    function automatic int ew_cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ew_log_fifo.sv
// Synchronous FIFO for log records: valid/ready pop, full/empty flags, push accepted when full if a pop happens in the same cycle.
module ew_log_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW+1)'(1);
        if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/ew_threat_ctrl.sv
// N-channel threat/comm controller: classify samples, hop channels on jam, authenticate spoofs, log events.
// Build option EW_TIMESTAMP_EN prepends a free-running 16-bit cycle stamp to every log record.
module ew_threat_ctrl
    import ew_sim_pkg::*;
#(
    parameter int DW         = 8,
    parameter int N_CH       = 4,
    parameter int JAM_THR    = 200,
    parameter int SPOOF_CODE = 123,
    parameter int AUTH_KEY   = 'hA5,
    parameter int AUTH_CYC   = 8,
    parameter int RECOV_CYC  = 4,
    parameter int MAX_HOPS   = 6,
    parameter int LOG_DEPTH  = 8,
    localparam int CH_W      = $clog2(N_CH),
    localparam int LOG_W     = ew_log_width(DW, N_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DW-1:0]     signal_in,
    input  logic [DW-1:0]     command_in,
    input  logic [N_CH*DW-1:0] ch_freq,
    input  logic              fault_clr,
    output logic [2:0]        fsm_state,
    output logic [CH_W-1:0]   comm_channel,
    output logic [DW-1:0]     comm_freq,
    output logic              system_fault,
    output logic [15:0]       hop_count,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [LOG_W-1:0]  log_data,
    output logic              log_overflow
);

    localparam int AT_W = ew_cnt_width(AUTH_CYC);
    localparam int RT_W = ew_cnt_width(RECOV_CYC);
    localparam int JC_W = ew_cnt_width(MAX_HOPS);

    localparam logic [DW-1:0] JAM_V   = DW'(JAM_THR);
    localparam logic [DW-1:0] SPOOF_V = DW'(SPOOF_CODE);
    localparam logic [DW-1:0] KEY_V   = DW'(AUTH_KEY);

    ew_state_e        state_q, state_d;
    ew_threat_e       threat_q, threat_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic [DW-1:0]    freq_q;
    logic [15:0]      hops_q, hops_d;
    logic [JC_W-1:0]  jam_cnt_q, jam_cnt_d;
    logic [AT_W-1:0]  auth_q, auth_d;
    logic [RT_W-1:0]  rec_q, rec_d;
    logic [DW-1:0]    sig_q, sig_d;
    logic             fault_q, fault_d;
    logic             ovf_q, ovf_d;
    logic             log_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             is_jam;
    logic             is_spoof;
    logic [DW-1:0]    ch_tbl [N_CH];
    ew_log_meta_t     meta;
    logic [LOG_W-1:0] rec;

    always_comb begin
        for (int i = 0; i < N_CH; i++) ch_tbl[i] = ch_freq[i*DW +: DW];
    end

    // Jam classification has priority over the spoof code.
    assign is_jam   = (signal_in >= JAM_V);
    assign is_spoof = !is_jam && (signal_in == SPOOF_V);

    always_comb begin
        state_d   = state_q;
        threat_d  = threat_q;
        chan_d    = chan_q;
        hops_d    = hops_q;
        jam_cnt_d = jam_cnt_q;
        auth_d    = auth_q;
        rec_d     = rec_q;
        sig_d     = sig_q;
        fault_d   = fault_q;
        ovf_d     = ovf_q;
        log_push  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_jam) begin
                        state_d  = ST_JAMMED;
                        sig_d    = signal_in;
                        threat_d = THR_JAM;
                    end else if (is_spoof) begin
                        state_d  = ST_SPOOF_DETECTED;
                        sig_d    = signal_in;
                        threat_d = THR_SPOOF_CONF;
                    end else begin
                        jam_cnt_d = '0;
                    end
                end
            end
            ST_JAMMED: begin
                chan_d    = (chan_q == CH_W'(N_CH-1)) ? '0 : chan_q + CH_W'(1);
                hops_d    = (hops_q == 16'hFFFF) ? hops_q : hops_q + 16'd1;
                jam_cnt_d = jam_cnt_q + JC_W'(1);
                if (jam_cnt_q == JC_W'(MAX_HOPS-1)) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    state_d = ST_RECOVERY;
                    rec_d   = RT_W'(RECOV_CYC);
                end
            end
            ST_SPOOF_DETECTED: begin
                auth_d  = AT_W'(AUTH_CYC);
                state_d = ST_AUTHENTICATING;
            end
            ST_AUTHENTICATING: begin
                auth_d = auth_q - AT_W'(1);
                if (in_valid && command_in == KEY_V) begin
                    state_d  = ST_RECOVERY;
                    threat_d = THR_SPOOF_CLR;
                    rec_d    = RT_W'(RECOV_CYC);
                end else if (auth_q == AT_W'(1)) begin
                    state_d  = ST_THREAT_KNOWN;
                    threat_d = THR_SPOOF_CONF;
                end
            end
            ST_THREAT_KNOWN: begin
                state_d = ST_LOGGING;
            end
            ST_RECOVERY: begin
                rec_d = rec_q - RT_W'(1);
                if (rec_q == RT_W'(1)) state_d = ST_LOGGING;
            end
            ST_LOGGING: begin
                log_push = 1'b1;
                if (fifo_full && !log_ready) ovf_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d   = ST_IDLE;
                    fault_d   = 1'b0;
                    jam_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            threat_q  <= THR_NONE;
            chan_q    <= '0;
            freq_q    <= '0;
            hops_q    <= '0;
            jam_cnt_q <= '0;
            auth_q    <= '0;
            rec_q     <= '0;
            sig_q     <= '0;
            fault_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            threat_q  <= threat_d;
            chan_q    <= chan_d;
            freq_q    <= ch_tbl[chan_q];
            hops_q    <= hops_d;
            jam_cnt_q <= jam_cnt_d;
            auth_q    <= auth_d;
            rec_q     <= rec_d;
            sig_q     <= sig_d;
            fault_q   <= fault_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef EW_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts_q <= '0;
        else          ts_q <= ts_q + TS_W'(1);
    end
`endif

    always_comb begin
        meta        = '0;
        meta.threat = threat_q;
`ifdef EW_TIMESTAMP_EN
        meta.stamp  = ts_q;
`endif
    end

    assign rec = {meta, chan_q, sig_q};

    ew_log_fifo #(
        .W     (LOG_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (log_push),
        .data_i  (rec),
        .pop_i   (log_ready),
        .data_o  (log_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign fsm_state    = state_q;
    assign comm_channel = chan_q;
    assign comm_freq    = freq_q;
    assign system_fault = fault_q;
    assign hop_count    = hops_q;
    assign log_valid    = !fifo_empty;
    assign log_overflow = ovf_q;

endmodule
